// File: rtl/alu_pkg.sv
// Shared types for the ALU operand sequencer: FSM state codes and operation selects.
package alu_pkg;

    localparam int N_MIN = 3;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } seq_state_t;

    typedef enum logic [2:0] {
        AND     = 3'b000,
        OR      = 3'b001,
        XOR     = 3'b010,
        SHIFT_R = 3'b011,
        SHIFT_L = 3'b100,
        CIRC    = 3'b101
    } alu_op_t;

    // Codes 110 and 111 have no operation of their own and behave as AND.
    function automatic alu_op_t decode_op(input logic [2:0] code);
        alu_op_t op;
        case (code)
            3'b000:  op = AND;
            3'b001:  op = OR;
            3'b010:  op = XOR;
            3'b011:  op = SHIFT_R;
            3'b100:  op = SHIFT_L;
            3'b101:  op = CIRC;
            default: op = AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Operand/result bundle between the sequencer (master) and the combinational logic mux (slave).
interface alu_operand_sequencer_if #(
    parameter int N = 4
);
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   s;
    logic         issue;
    logic [N-1:0] result_in;

    modport master (
        output A,
        output B,
        output s,
        output issue,
        input  result_in
    );

    modport slave (
        input  A,
        input  B,
        input  s,
        input  issue,
        output result_in
    );
endinterface

// File: rtl/edge_detect.sv
// Registered rising-edge detector; RST_VAL=1 suppresses a false edge for a level held through reset.
module edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);
    logic level_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= RST_VAL;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Loads A, B and the op select from the switch bus one press at a time, then captures the mux result.
// Optional result flags built only when ALU_FLAGS_EN is defined.
//
// state  | meaning
// S_A    | waiting for operand A press
// S_B    | waiting for operand B press
// S_OP   | waiting for operation select press
// S_EXEC | operands committed, issue pulse, mux settling
// S_SHOW | result held; a press starts the next sequence with A
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              sw_in,
    input  logic                      load,
    input  logic                      clear,
    alu_operand_sequencer_if.master   mux,
    output logic [N-1:0]              result_q,
    output logic                      result_valid,
    output logic                      flag_z,
    output logic                      flag_p,
    output logic [2:0]                state
);

    if (N < N_MIN) begin : g_bad_n
        $error("alu_operand_sequencer: N must be at least 3");
    end

    seq_state_t   state_q;
    seq_state_t   state_d;
    logic         load_edge;
    logic         load_a;
    logic         load_b;
    logic         load_s;
    logic         capture;
    logic         drop_valid;
    logic         abort;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [2:0]   s_q;
    logic         valid_q;
    logic [N-1:0] res_q;

    edge_detect #(
        .RST_VAL (1'b1)
    ) u_load_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (load),
        .rise  (load_edge)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_s     = 1'b0;
        capture    = 1'b0;
        drop_valid = 1'b0;
        abort      = 1'b0;
        if (clear) begin
            // Clear swallows any load edge arriving in the same cycle.
            abort   = 1'b1;
            state_d = S_A;
        end else begin
            case (state_q)
                S_A: begin
                    if (load_edge) begin
                        load_a  = 1'b1;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (load_edge) begin
                        load_b  = 1'b1;
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (load_edge) begin
                        load_s  = 1'b1;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    capture = 1'b1;
                    state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (load_edge) begin
                        load_a     = 1'b1;
                        drop_valid = 1'b1;
                        state_d    = S_B;
                    end
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
            res_q   <= '0;
        end else if (abort) begin
            // Result register keeps its last value so the LEDs still show it.
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load_a) begin
                a_q <= sw_in;
            end
            if (load_b) begin
                b_q <= sw_in;
            end
            if (load_s) begin
                s_q <= sw_in[2:0];
            end
            if (capture) begin
                res_q   <= mux.result_in;
                valid_q <= 1'b1;
            end else if (drop_valid) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef ALU_FLAGS_EN
    logic z_q;
    logic p_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            p_q <= 1'b0;
        end else if (abort) begin
            z_q <= 1'b0;
            p_q <= 1'b0;
        end else if (capture) begin
            z_q <= (mux.result_in == '0);
            p_q <= ^mux.result_in;
        end
    end

    assign flag_z = z_q;
    assign flag_p = p_q;
`else
    assign flag_z = 1'b0;
    assign flag_p = 1'b0;
`endif

    assign mux.A        = a_q;
    assign mux.B        = b_q;
    assign mux.s        = s_q;
    assign mux.issue    = (state_q == S_EXEC);
    assign result_q     = res_q;
    assign result_valid = valid_q;
    assign state        = state_q;

endmodule
